// File: rtl/mem_stage_ctrl.sv
//==============================================================================
// mem_stage_ctrl : MEM pipeline stage that runs the valid/ready data-memory
//                  port, stalls the pipeline for each access, captures load
//                  data and resolves pcSrc.
// Optional feature: MEM_TIMEOUT_EN (watchdog abort of stuck accesses).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_stage_ctrl #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       memPCBranch,
  input  logic              memZero,
  input  logic [31:0]       memALUOutput,
  input  logic [31:0]       memRS2,
  input  logic [4:0]        memWriteDir,
  input  logic              memRegWrite,
  input  logic              memMemToReg,
  input  logic              memBranch,
  input  logic              memMemWrite,
  input  logic              memMemRead,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic              dmem_we,
  input  logic              dmem_rvalid,
  input  logic [31:0]       dmem_rdata,
  output logic              stall,
  output logic              pcSrc,
  output logic [31:0]       pcBranch,
  output logic [31:0]       wbReadData,
  output logic [31:0]       wbALUOutput,
  output logic [4:0]        wbWriteDir,
  output logic              wbRegWrite,
  output logic              wbMemToReg,
  output logic              misalign,
  output logic              memErr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_mem_op;
  logic        w_misal;
  logic        w_capture;
  logic        w_misal_evt;
  logic        w_timeout;
  logic        w_abort_mask;
  logic [31:0] r_rdata;
  logic        r_misal;

  assign w_mem_op = memMemRead | memMemWrite;
  assign w_misal  = (memALUOutput[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_memErr;
  logic            w_wd_hit;

  assign w_wd_hit = (r_wd == c_wd_last);
`endif

  always_comb begin
    w_next         = r_state;
    dmem_req_valid = 1'b0;
    stall          = 1'b0;
    w_capture      = 1'b0;
    w_misal_evt    = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          if (!w_misal) begin
            dmem_req_valid = 1'b1;
            stall          = 1'b1;
            if (dmem_req_ready) w_next = memMemWrite ? S_DONE : S_RESP;
            else                w_next = S_REQ;
          end else begin
            // Misaligned op is dropped: it leaves this cycle as a no-op.
            w_misal_evt = 1'b1;
          end
        end
      end
      S_REQ: begin
        dmem_req_valid = 1'b1;
        stall          = 1'b1;
        if (dmem_req_ready) begin
          w_next = memMemWrite ? S_DONE : S_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
`endif
      end
      S_RESP: begin
        stall = 1'b1;
        if (dmem_rvalid) begin
          w_capture = 1'b1;
          w_next    = S_DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (w_wd_hit) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
`endif
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rdata <= 32'd0;
      r_misal <= 1'b0;
    end else begin
      r_state <= w_next;
      r_misal <= w_misal_evt;
      if (w_capture) r_rdata <= dmem_rdata;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wd     <= '0;
      r_memErr <= 1'b0;
    end else begin
      r_memErr <= w_timeout;
      if ((r_state == S_REQ) || (r_state == S_RESP)) r_wd <= r_wd + 1'b1;
      else                                           r_wd <= '0;
    end
  end

  // r_memErr is high exactly in the DONE cycle of an aborted access.
  assign w_abort_mask = r_memErr;
  assign memErr       = r_memErr;
`else
  assign w_abort_mask = 1'b0;
  assign memErr       = 1'b0;
`endif

  assign dmem_addr   = memALUOutput[ADDR_W-1:0];
  assign dmem_wdata  = memRS2;
  assign dmem_we     = memMemWrite;

  assign pcSrc       = memBranch & memZero & ~stall;
  assign pcBranch    = memPCBranch;
  assign wbReadData  = r_rdata;
  assign wbALUOutput = memALUOutput;
  assign wbWriteDir  = memWriteDir;
  assign wbMemToReg  = memMemToReg;
  assign wbRegWrite  = memRegWrite & ~w_misal_evt & ~w_abort_mask;
  assign misalign    = r_misal;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// Directed testbench for mem_stage_ctrl: inputs change on negedge, outputs sampled 1 time unit later.
`default_nettype none

module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memPCBranch, memALUOutput, memRS2;
  logic        memZero, memRegWrite, memMemToReg, memBranch, memMemWrite, memMemRead;
  logic [4:0]  memWriteDir;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        stall, pcSrc, wbRegWrite, wbMemToReg, misalign, memErr;
  logic [31:0] pcBranch, wbReadData, wbALUOutput;
  logic [4:0]  wbWriteDir;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
`else
  mem_stage_ctrl #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
`endif
    .clk(clk), .rst(rst),
    .memPCBranch(memPCBranch), .memZero(memZero), .memALUOutput(memALUOutput),
    .memRS2(memRS2), .memWriteDir(memWriteDir), .memRegWrite(memRegWrite),
    .memMemToReg(memMemToReg), .memBranch(memBranch), .memMemWrite(memMemWrite),
    .memMemRead(memMemRead), .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .stall(stall), .pcSrc(pcSrc),
    .pcBranch(pcBranch), .wbReadData(wbReadData), .wbALUOutput(wbALUOutput),
    .wbWriteDir(wbWriteDir), .wbRegWrite(wbRegWrite), .wbMemToReg(wbMemToReg),
    .misalign(misalign), .memErr(memErr)
  );

  task automatic set_nop();
    memPCBranch = 32'd0; memZero = 1'b0; memALUOutput = 32'd0; memRS2 = 32'd0;
    memWriteDir = 5'd0; memRegWrite = 1'b0; memMemToReg = 1'b0; memBranch = 1'b0;
    memMemWrite = 1'b0; memMemRead = 1'b0;
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
  endtask

  task automatic set_load(input logic [31:0] addr);
    set_nop();
    memALUOutput = addr; memMemRead = 1'b1; memRegWrite = 1'b1; memMemToReg = 1'b1;
    memWriteDir = 5'd7;
  endtask

  task automatic test_reset();
    set_nop();
    rst = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dmem_req_valid); end
    checks++; if (wbReadData !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", wbReadData); end
    checks++; if (misalign !== 1'b0 || memErr !== 1'b0) begin errors++; $display("FAIL reset_pulses misalign=%b memErr=%b exp=0,0", misalign, memErr); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk);
    set_load(32'h10); dmem_req_ready = 1'b1;
    #1;
    checks++; if ({dmem_req_valid, stall, dmem_we} !== 3'b110) begin errors++; $display("FAIL load_issue valid/stall/we got=%b exp=110", {dmem_req_valid, stall, dmem_we}); end
    checks++; if (dmem_addr !== 32'h10) begin errors++; $display("FAIL load_addr got=%h exp=00000010", dmem_addr); end
    @(negedge clk);
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if ({dmem_req_valid, stall} !== 2'b01) begin errors++; $display("FAIL load_resp valid/stall got=%b exp=01", {dmem_req_valid, stall}); end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    checks++; if ({dmem_req_valid, stall} !== 2'b00) begin errors++; $display("FAIL load_done valid/stall got=%b exp=00", {dmem_req_valid, stall}); end
    checks++; if (wbReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL load_data got=%h exp=deadbeef", wbReadData); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_store_wait();
    @(negedge clk);
    set_nop();
    memALUOutput = 32'h20; memRS2 = 32'h12345678; memMemWrite = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dmem_req_ready = (i == 3);
      #1;
      checks++;
      if ({dmem_req_valid, stall, dmem_we} !== 3'b111 || dmem_addr !== 32'h20 || dmem_wdata !== 32'h12345678) begin
        errors++;
        $display("FAIL store_hold cyc=%0d v/s/we=%b addr=%h wdata=%h exp=111 00000020 12345678",
                 i, {dmem_req_valid, stall, dmem_we}, dmem_addr, dmem_wdata);
      end
      @(negedge clk);
    end
    dmem_req_ready = 1'b0;
    #1;
    checks++; if ({dmem_req_valid, stall} !== 2'b00) begin errors++; $display("FAIL store_done valid/stall got=%b exp=00", {dmem_req_valid, stall}); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_branch();
    @(negedge clk);
    set_nop();
    memALUOutput = 32'h55; memWriteDir = 5'd5; memRegWrite = 1'b1;
    #1;
    checks++; if ({stall, pcSrc, wbRegWrite} !== 3'b001) begin errors++; $display("FAIL alu_ctrl stall/pcSrc/regw got=%b exp=001", {stall, pcSrc, wbRegWrite}); end
    checks++; if (wbALUOutput !== 32'h55 || wbWriteDir !== 5'd5) begin errors++; $display("FAIL alu_pass alu=%h dir=%0d exp=00000055 5", wbALUOutput, wbWriteDir); end
    @(negedge clk);
    set_nop();
    memBranch = 1'b1; memZero = 1'b1; memPCBranch = 32'h400;
    #1;
    checks++; if ({stall, pcSrc} !== 2'b01 || pcBranch !== 32'h400) begin errors++; $display("FAIL branch_taken stall/pcSrc=%b pcBranch=%h exp=01 00000400", {stall, pcSrc}, pcBranch); end
    @(negedge clk);
    memZero = 1'b0;
    #1;
    checks++; if (pcSrc !== 1'b0) begin errors++; $display("FAIL branch_not_taken pcSrc=%b exp=0", pcSrc); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_misalign();
    @(negedge clk);
    set_load(32'h13); dmem_req_ready = 1'b1;
    #1;
    checks++; if ({dmem_req_valid, stall, wbRegWrite, misalign} !== 4'b0000) begin errors++; $display("FAIL misal_issue v/s/regw/mis got=%b exp=0000", {dmem_req_valid, stall, wbRegWrite, misalign}); end
    @(negedge clk);
    set_nop();
    #1;
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL misal_pulse got=%b exp=1", misalign); end
    @(negedge clk);
    #1;
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL misal_single got=%b exp=0", misalign); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set_nop();
    memALUOutput = 32'h40; memRS2 = 32'hA5A5A5A5; memMemWrite = 1'b1; dmem_req_ready = 1'b1;
    #1;
    checks++; if ({dmem_req_valid, stall} !== 2'b11) begin errors++; $display("FAIL b2b_store v/s got=%b exp=11", {dmem_req_valid, stall}); end
    @(negedge clk);
    #1;
    checks++; if ({dmem_req_valid, stall} !== 2'b00) begin errors++; $display("FAIL b2b_store_done v/s got=%b exp=00", {dmem_req_valid, stall}); end
    @(negedge clk);
    set_load(32'h44); dmem_req_ready = 1'b1;
    #1;
    checks++; if ({dmem_req_valid, dmem_we} !== 2'b10 || dmem_addr !== 32'h44) begin errors++; $display("FAIL b2b_load v/we=%b addr=%h exp=10 00000044", {dmem_req_valid, dmem_we}, dmem_addr); end
    @(negedge clk);
    dmem_req_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    checks++; if (wbReadData !== 32'h0BADF00D || stall !== 1'b0) begin errors++; $display("FAIL b2b_load_data got=%h stall=%b exp=0badf00d 0", wbReadData, stall); end
    @(negedge clk);
    set_nop();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    set_load(32'h30); dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #1;
    checks++; if ({dmem_req_valid, stall} !== 2'b01) begin errors++; $display("FAIL rstmid_in_resp v/s got=%b exp=01", {dmem_req_valid, stall}); end
    rst = 1'b0;
    #1;
    // Load still presented: an IDLE state re-requests, RESP would not.
    checks++; if (dmem_req_valid !== 1'b1) begin errors++; $display("FAIL rstmid_idle valid got=%b exp=1", dmem_req_valid); end
    checks++; if (wbReadData !== 32'd0) begin errors++; $display("FAIL rstmid_rdata got=%h exp=0", wbReadData); end
    set_nop();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    dmem_rvalid = 1'b0;
    #1;
    checks++; if (wbReadData !== 32'd0 || stall !== 1'b0) begin errors++; $display("FAIL rstmid_drop rdata=%h stall=%b exp=0 0", wbReadData, stall); end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit seen;
    @(negedge clk);
    set_load(32'h50);
    n = 0; seen = 1'b0;
    #1;
    while (stall === 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL tmo_stall_cycles got=%0d exp=9", n); end
    checks++; if ({memErr, wbRegWrite} !== 2'b10) begin errors++; $display("FAIL tmo_done memErr/regw got=%b exp=10", {memErr, wbRegWrite}); end
    seen = memErr;
    @(negedge clk);
    set_nop();
    #1;
    checks++; if (seen !== 1'b1 || memErr !== 1'b0) begin errors++; $display("FAIL tmo_pulse memErr=%b exp=0", memErr); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store_wait();
    test_branch();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
